// File: rtl/ibexc_trace_buffer_if.sv
// ==========================================================================
// ibexc_trace_buffer_if -- RVFI snoop, control and read-port bundle (rev 1.0)
// ==========================================================================
`default_nettype none

interface ibexc_trace_buffer_if #(
  parameter int Depth    = 16,
  parameter int SeqWidth = 16
);
  localparam int CntW = $clog2(Depth + 1);

  logic                enable_i;
  logic [1:0]          mode_i;
  logic                clear_i;
  logic                rvfi_valid_i;
  logic [63:0]         rvfi_order_i;
  logic [31:0]         rvfi_pc_rdata_i;
  logic [31:0]         rvfi_insn_i;
  logic                rvfi_trap_i;
  logic [4:0]          rvfi_rd_addr_i;
  logic [31:0]         rvfi_rd_wdata_i;
  logic                rvfi_rd_wtag_i;
  logic                rd_valid_o;
  logic                rd_ready_i;
  logic [31:0]         rd_pc_o;
  logic [31:0]         rd_insn_o;
  logic [31:0]         rd_wdata_o;
  logic [4:0]          rd_rd_addr_o;
  logic                rd_tag_o;
  logic                rd_trap_o;
  logic [SeqWidth-1:0] rd_seq_o;
  logic [CntW-1:0]     count_o;
  logic [15:0]         drop_cnt_o;
  logic                triggered_o;
  logic                frozen_o;

  modport master (
    output enable_i, mode_i, clear_i, rvfi_valid_i, rvfi_order_i, rvfi_pc_rdata_i,
           rvfi_insn_i, rvfi_trap_i, rvfi_rd_addr_i, rvfi_rd_wdata_i, rvfi_rd_wtag_i,
           rd_ready_i,
    input  rd_valid_o, rd_pc_o, rd_insn_o, rd_wdata_o, rd_rd_addr_o, rd_tag_o,
           rd_trap_o, rd_seq_o, count_o, drop_cnt_o, triggered_o, frozen_o
  );

  modport slave (
    input  enable_i, mode_i, clear_i, rvfi_valid_i, rvfi_order_i, rvfi_pc_rdata_i,
           rvfi_insn_i, rvfi_trap_i, rvfi_rd_addr_i, rvfi_rd_wdata_i, rvfi_rd_wtag_i,
           rd_ready_i,
    output rd_valid_o, rd_pc_o, rd_insn_o, rd_wdata_o, rd_rd_addr_o, rd_tag_o,
           rd_trap_o, rd_seq_o, count_o, drop_cnt_o, triggered_o, frozen_o
  );
endinterface

`default_nettype wire

// File: rtl/ibexc_trace_buffer.sv
// ==========================================================================
// ibexc_trace_buffer -- RVFI retirement trace ring with trap freeze (rev 1.0)
// ==========================================================================
`default_nettype none

module ibexc_trace_buffer #(
  parameter int Depth    = 16,
  parameter int SeqWidth = 16,
  parameter int PostTrig = 8
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  ibexc_trace_buffer_if.slave bus
);
  localparam int PtrW = $clog2(Depth);
  localparam int CntW = $clog2(Depth + 1);

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_POST   = 2'd1;
  localparam logic [1:0] ST_FROZEN = 2'd2;

  typedef struct packed {
    logic [31:0]         pc;
    logic [31:0]         insn;
    logic [31:0]         wdata;
    logic [4:0]          rd_addr;
    logic                tag;
    logic                trap;
    logic [SeqWidth-1:0] seq;
  } rec_t;

  rec_t            mem [Depth];
  rec_t            new_rec;
  logic [PtrW-1:0] wr_ptr;
  logic [PtrW-1:0] rd_ptr;
  logic [CntW-1:0] count;
  logic [15:0]     drop_cnt;
  logic [PtrW-1:0] post_cnt;
  logic [1:0]      state;
  logic [1:0]      state_next;
  logic            frozen;
  logic            triggered;

  logic capture;
  logic pop;
  logic full;
  logic overwrite;
  logic wr_en;
  logic rd_inc;
  logic drop;
  logic trig_hit;

  assign overwrite = (bus.mode_i == 2'd1) || (bus.mode_i == 2'd2);
  assign full      = (count == CntW'(Depth));
  assign capture   = bus.rvfi_valid_i && bus.enable_i && !bus.clear_i && (state != ST_FROZEN);
  assign pop       = (count != '0) && bus.rd_ready_i;
  assign wr_en     = capture && (!full || pop || overwrite);
  // Overwriting a full ring without a pop discards the oldest entry.
  assign rd_inc    = pop || (wr_en && full);
  assign drop      = capture && full && !pop && !overwrite;
  assign trig_hit  = capture && (bus.mode_i == 2'd2) && bus.rvfi_trap_i && (state == ST_RUN);

  assign new_rec = {bus.rvfi_pc_rdata_i, bus.rvfi_insn_i, bus.rvfi_rd_wdata_i,
                    bus.rvfi_rd_addr_i, bus.rvfi_rd_wtag_i, bus.rvfi_trap_i,
                    bus.rvfi_order_i[SeqWidth-1:0]};

  generate
    if (SeqWidth < 64) begin : g_order_unused
      logic unused_order_hi;
      assign unused_order_hi = ^bus.rvfi_order_i[63:SeqWidth];
    end
  endgenerate

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < Depth; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[wr_ptr] <= new_rec;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      drop_cnt <= '0;
    end else if (bus.clear_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      drop_cnt <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + PtrW'(1);
      end
      if (rd_inc) begin
        rd_ptr <= rd_ptr + PtrW'(1);
      end
      case ({wr_en, rd_inc})
        2'b10:   count <= count + CntW'(1);
        2'b01:   count <= count - CntW'(1);
        default: count <= count;
      endcase
      if (drop && (drop_cnt != 16'hFFFF)) begin
        drop_cnt <= drop_cnt + 16'd1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      post_cnt <= '0;
    end else if (bus.clear_i) begin
      post_cnt <= '0;
    end else if (trig_hit) begin
      post_cnt <= PtrW'(PostTrig);
    end else if ((state == ST_POST) && capture) begin
      post_cnt <= post_cnt - PtrW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= ST_RUN;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (bus.clear_i) begin
      state_next = ST_RUN;
    end else begin
      case (state)
        ST_RUN: begin
          if (trig_hit) begin
            state_next = (PostTrig == 0) ? ST_FROZEN : ST_POST;
          end
        end
        ST_POST: begin
          if (capture && (post_cnt == PtrW'(1))) begin
            state_next = ST_FROZEN;
          end
        end
        ST_FROZEN: state_next = ST_FROZEN;
        default:   state_next = ST_RUN;
      endcase
    end
  end

  always_comb begin
    frozen    = (state == ST_FROZEN);
    triggered = (state != ST_RUN);
  end

  assign bus.rd_valid_o   = (count != '0);
  assign bus.rd_pc_o      = mem[rd_ptr].pc;
  assign bus.rd_insn_o    = mem[rd_ptr].insn;
  assign bus.rd_wdata_o   = mem[rd_ptr].wdata;
  assign bus.rd_rd_addr_o = mem[rd_ptr].rd_addr;
  assign bus.rd_tag_o     = mem[rd_ptr].tag;
  assign bus.rd_trap_o    = mem[rd_ptr].trap;
  assign bus.rd_seq_o     = mem[rd_ptr].seq;
  assign bus.count_o      = count;
  assign bus.drop_cnt_o   = drop_cnt;
  assign bus.triggered_o  = triggered;
  assign bus.frozen_o     = frozen;

endmodule

`default_nettype wire

// File: tb/tb_ibexc_trace_buffer.sv
// ==========================================================================
// tb_ibexc_trace_buffer -- randomized bench with queue reference model (rev 1.0)
// ==========================================================================
`default_nettype none

module tb_ibexc_trace_buffer;
  localparam int DEPTH     = 16;
  localparam int SEQW      = 16;
  localparam int POST_TRIG = 8;
  localparam int CW        = $clog2(DEPTH + 1);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        en, clr, valid, ready, trap, tag;
  logic [1:0]  mode;
  logic [63:0] order;
  logic [31:0] pc, insn, wdata;
  logic [4:0]  rd;

  ibexc_trace_buffer_if #(.Depth(DEPTH), .SeqWidth(SEQW)) bus ();
  ibexc_trace_buffer_if #(.Depth(DEPTH), .SeqWidth(SEQW)) bus0 ();

  assign bus.enable_i        = en;
  assign bus.mode_i          = mode;
  assign bus.clear_i         = clr;
  assign bus.rvfi_valid_i    = valid;
  assign bus.rvfi_order_i    = order;
  assign bus.rvfi_pc_rdata_i = pc;
  assign bus.rvfi_insn_i     = insn;
  assign bus.rvfi_trap_i     = trap;
  assign bus.rvfi_rd_addr_i  = rd;
  assign bus.rvfi_rd_wdata_i = wdata;
  assign bus.rvfi_rd_wtag_i  = tag;
  assign bus.rd_ready_i      = ready;

  assign bus0.enable_i        = en;
  assign bus0.mode_i          = mode;
  assign bus0.clear_i         = clr;
  assign bus0.rvfi_valid_i    = valid;
  assign bus0.rvfi_order_i    = order;
  assign bus0.rvfi_pc_rdata_i = pc;
  assign bus0.rvfi_insn_i     = insn;
  assign bus0.rvfi_trap_i     = trap;
  assign bus0.rvfi_rd_addr_i  = rd;
  assign bus0.rvfi_rd_wdata_i = wdata;
  assign bus0.rvfi_rd_wtag_i  = tag;
  assign bus0.rd_ready_i      = ready;

  ibexc_trace_buffer #(.Depth(DEPTH), .SeqWidth(SEQW), .PostTrig(POST_TRIG)) dut (
    .clk_i (clk), .rst_ni (rst_n), .bus (bus)
  );
  ibexc_trace_buffer #(.Depth(DEPTH), .SeqWidth(SEQW), .PostTrig(0)) dut0 (
    .clk_i (clk), .rst_ni (rst_n), .bus (bus0)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] insn;
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic        tag;
    logic        trap;
    logic [15:0] seq;
  } rec_t;

  // Reference model of the PostTrig=8 instance: a plain queue, oldest at the front.
  rec_t mq[$];
  int   mdrop;
  bit   mtrig, mfrz;
  int   mpost;

  int vectors = 0;
  int miscompares = 0;

  function automatic rec_t got_rec();
    return {bus.rd_pc_o, bus.rd_insn_o, bus.rd_wdata_o, bus.rd_rd_addr_o,
            bus.rd_tag_o, bus.rd_trap_o, bus.rd_seq_o};
  endfunction

  task automatic model_reset();
    mq.delete();
    mdrop = 0;
    mtrig = 1'b0;
    mfrz  = 1'b0;
    mpost = 0;
  endtask

  task automatic model_update();
    rec_t r;
    bit   do_pop, cap, was_trig;
    if (clr) begin
      model_reset();
      return;
    end
    do_pop   = (mq.size() != 0) && ready;
    cap      = valid && en && !mfrz;
    was_trig = mtrig;
    if (do_pop) void'(mq.pop_front());
    if (cap) begin
      r = {pc, insn, wdata, rd, tag, trap, order[15:0]};
      if (mq.size() < DEPTH) begin
        mq.push_back(r);
      end else if (mode == 2'd1 || mode == 2'd2) begin
        void'(mq.pop_front());
        mq.push_back(r);
      end else if (mdrop < 65535) begin
        mdrop++;
      end
      if (mode == 2'd2) begin
        if (!was_trig && trap) begin
          mtrig = 1'b1;
          if (POST_TRIG == 0) mfrz = 1'b1;
          else mpost = POST_TRIG;
        end else if (was_trig) begin
          mpost--;
          if (mpost == 0) mfrz = 1'b1;
        end
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic set_rec(input int ord, input bit tr);
    valid = 1'b1;
    order = {$urandom, 32'(ord)};
    pc    = $urandom;
    insn  = $urandom;
    wdata = $urandom;
    rd    = 5'($urandom);
    tag   = 1'($urandom);
    trap  = tr;
  endtask

  task automatic do_clear(input logic [1:0] m);
    mode  = m;
    clr   = 1'b1;
    valid = 1'b0;
    ready = 1'b0;
    trap  = 1'b0;
    cycle();
    clr = 1'b0;
  endtask

  task automatic test_reset();
    vectors++;
    if (bus.rd_valid_o !== 1'b0 || bus.count_o !== '0) begin
      miscompares++;
      $display("FAIL reset_occupancy: got valid=%0b count=%0d exp 0/0", bus.rd_valid_o, bus.count_o);
    end
    vectors++;
    if (bus.drop_cnt_o !== 16'd0 || bus.triggered_o !== 1'b0 || bus.frozen_o !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_status: got drop=%0d trig=%0b frz=%0b exp 0", bus.drop_cnt_o, bus.triggered_o, bus.frozen_o);
    end
    vectors++;
    if (got_rec() !== '0) begin
      miscompares++;
      $display("FAIL reset_payload: got %h exp 0", got_rec());
    end
  endtask

  task automatic test_fifo();
    do_clear(2'd0);
    ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      set_rec(i, 1'b0);
      cycle();
    end
    valid = 1'b0;
    vectors++;
    if (bus.count_o !== CW'(16) || bus.drop_cnt_o !== 16'd4) begin
      miscompares++;
      $display("FAIL fifo_full: got count=%0d drop=%0d exp 16/4", bus.count_o, bus.drop_cnt_o);
    end
    for (int i = 0; i < 16; i++) begin
      vectors++;
      if (bus.rd_valid_o !== 1'b1 || bus.rd_seq_o !== 16'(i) || got_rec() !== mq[0]) begin
        miscompares++;
        $display("FAIL fifo_drain[%0d]: got seq=%0d rec=%h exp seq=%0d rec=%h", i, bus.rd_seq_o, got_rec(), i, mq[0]);
      end
      ready = 1'b1;
      cycle();
    end
    ready = 1'b0;
    vectors++;
    if (bus.rd_valid_o !== 1'b0 || bus.count_o !== '0) begin
      miscompares++;
      $display("FAIL fifo_empty: got valid=%0b count=%0d exp 0/0", bus.rd_valid_o, bus.count_o);
    end
  endtask

  task automatic test_overwrite();
    do_clear(2'd1);
    for (int i = 0; i < 20; i++) begin
      set_rec(i, 1'b0);
      cycle();
    end
    valid = 1'b0;
    vectors++;
    if (bus.count_o !== CW'(16) || bus.drop_cnt_o !== 16'd0) begin
      miscompares++;
      $display("FAIL ovw_full: got count=%0d drop=%0d exp 16/0", bus.count_o, bus.drop_cnt_o);
    end
    for (int i = 0; i < 16; i++) begin
      vectors++;
      if (bus.rd_seq_o !== 16'(i + 4) || got_rec() !== mq[0]) begin
        miscompares++;
        $display("FAIL ovw_drain[%0d]: got seq=%0d exp seq=%0d", i, bus.rd_seq_o, i + 4);
      end
      ready = 1'b1;
      cycle();
    end
    ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      set_rec(100 + i, 1'b0);
      cycle();
    end
    for (int i = 0; i < 10; i++) begin
      set_rec(200 + i, 1'b0);
      ready = 1'b1;
      cycle();
      vectors++;
      if (bus.count_o !== CW'(16) || mq.size() != 16 || got_rec() !== mq[0]) begin
        miscompares++;
        $display("FAIL back_to_back[%0d]: got count=%0d rec=%h exp 16 rec=%h", i, bus.count_o, got_rec(), mq[0]);
      end
    end
    valid = 1'b0;
    ready = 1'b0;
  endtask

  task automatic test_trigger();
    do_clear(2'd2);
    for (int o = 0; o <= 50; o++) begin
      set_rec(o, o == 30);
      cycle();
      vectors++;
      if (bus.triggered_o !== (o >= 30) || bus.frozen_o !== (o >= 38)) begin
        miscompares++;
        $display("FAIL trig_flags[o=%0d]: got trig=%0b frz=%0b exp %0b/%0b", o, bus.triggered_o, bus.frozen_o, o >= 30, o >= 38);
      end
    end
    valid = 1'b0;
    trap  = 1'b0;
    vectors++;
    if (bus.count_o !== CW'(16) || bus.drop_cnt_o !== 16'd0 || bus0.count_o !== CW'(16)) begin
      miscompares++;
      $display("FAIL trig_count: got count=%0d drop=%0d count0=%0d exp 16/0/16", bus.count_o, bus.drop_cnt_o, bus0.count_o);
    end
    for (int i = 0; i < 16; i++) begin
      vectors++;
      if (bus.rd_seq_o !== 16'(23 + i) || bus.rd_trap_o !== (23 + i == 30) || got_rec() !== mq[0]) begin
        miscompares++;
        $display("FAIL trig_drain[%0d]: got seq=%0d trap=%0b exp seq=%0d trap=%0b", i, bus.rd_seq_o, bus.rd_trap_o, 23 + i, 23 + i == 30);
      end
      vectors++;
      if (bus0.rd_seq_o !== 16'(15 + i) || bus0.rd_trap_o !== (i == 15)) begin
        miscompares++;
        $display("FAIL trig0_drain[%0d]: got seq=%0d trap=%0b exp seq=%0d trap=%0b", i, bus0.rd_seq_o, bus0.rd_trap_o, 15 + i, i == 15);
      end
      ready = 1'b1;
      cycle();
    end
    ready = 1'b0;
    vectors++;
    if (bus.rd_valid_o !== 1'b0 || bus.frozen_o !== 1'b1) begin
      miscompares++;
      $display("FAIL trig_after_drain: got valid=%0b frz=%0b exp 0/1", bus.rd_valid_o, bus.frozen_o);
    end
  endtask

  task automatic test_trig_zero_and_clear();
    do_clear(2'd2);
    for (int o = 0; o < 10; o++) begin
      set_rec(o, o == 5);
      cycle();
    end
    valid = 1'b0;
    trap  = 1'b0;
    vectors++;
    if (bus0.count_o !== CW'(6) || bus0.frozen_o !== 1'b1 || bus0.triggered_o !== 1'b1) begin
      miscompares++;
      $display("FAIL trig0_state: got count=%0d frz=%0b trig=%0b exp 6/1/1", bus0.count_o, bus0.frozen_o, bus0.triggered_o);
    end
    for (int i = 0; i < 6; i++) begin
      vectors++;
      if (bus0.rd_seq_o !== 16'(i) || bus0.rd_trap_o !== (i == 5)) begin
        miscompares++;
        $display("FAIL trig0_zero_drain[%0d]: got seq=%0d trap=%0b exp seq=%0d trap=%0b", i, bus0.rd_seq_o, bus0.rd_trap_o, i, i == 5);
      end
      ready = 1'b1;
      cycle();
    end
    ready = 1'b0;
    // Four more captures finish the PostTrig=8 window of the main instance.
    for (int o = 10; o < 14; o++) begin
      set_rec(o, 1'b0);
      cycle();
    end
    vectors++;
    if (bus.frozen_o !== 1'b1 || bus.count_o !== CW'(mq.size()) || mfrz !== 1'b1) begin
      miscompares++;
      $display("FAIL clear_pre: got frz=%0b count=%0d exp 1/%0d", bus.frozen_o, bus.count_o, mq.size());
    end
    set_rec(99, 1'b1);
    ready = 1'b1;
    clr   = 1'b1;
    cycle();
    clr   = 1'b0;
    valid = 1'b0;
    ready = 1'b0;
    trap  = 1'b0;
    vectors++;
    if (bus.count_o !== '0 || bus.frozen_o !== 1'b0 || bus.triggered_o !== 1'b0 ||
        bus.drop_cnt_o !== 16'd0 || bus.rd_valid_o !== 1'b0) begin
      miscompares++;
      $display("FAIL clear_post: got count=%0d frz=%0b trig=%0b drop=%0d valid=%0b exp all 0",
               bus.count_o, bus.frozen_o, bus.triggered_o, bus.drop_cnt_o, bus.rd_valid_o);
    end
    cycle();
    vectors++;
    if (bus.count_o !== '0 || bus0.count_o !== '0 || bus0.frozen_o !== 1'b0) begin
      miscompares++;
      $display("FAIL clear_no_store: got count=%0d count0=%0d frz0=%0b exp 0/0/0", bus.count_o, bus0.count_o, bus0.frozen_o);
    end
  endtask

  task automatic test_random();
    for (int seg = 0; seg < 6; seg++) begin
      do_clear(2'($urandom_range(0, 3)));
      for (int c = 0; c < 300; c++) begin
        set_rec($urandom, ($urandom % 40) == 0);
        valid = ($urandom % 4) != 0;
        en    = ($urandom % 8) != 0;
        ready = ($urandom % 3) == 0;
        clr   = ($urandom % 150) == 0;
        if (clr) mode = 2'($urandom_range(0, 3));
        cycle();
        vectors++;
        if (bus.count_o !== CW'(mq.size()) || bus.rd_valid_o !== (mq.size() != 0)) begin
          miscompares++;
          $display("FAIL rand_count[%0d/%0d]: got count=%0d valid=%0b exp %0d", seg, c, bus.count_o, bus.rd_valid_o, mq.size());
        end
        vectors++;
        if (bus.drop_cnt_o !== 16'(mdrop) || bus.triggered_o !== mtrig || bus.frozen_o !== mfrz) begin
          miscompares++;
          $display("FAIL rand_status[%0d/%0d]: got drop=%0d trig=%0b frz=%0b exp %0d/%0b/%0b",
                   seg, c, bus.drop_cnt_o, bus.triggered_o, bus.frozen_o, mdrop, mtrig, mfrz);
        end
        if (mq.size() != 0) begin
          vectors++;
          if (got_rec() !== mq[0]) begin
            miscompares++;
            $display("FAIL rand_head[%0d/%0d]: got %h exp %h", seg, c, got_rec(), mq[0]);
          end
        end
      end
      clr = 1'b0;
      en  = 1'b1;
    end
  endtask

  task automatic test_drop_sat();
    do_clear(2'd0);
    for (int i = 0; i < 70016; i++) begin
      set_rec(i, 1'b0);
      cycle();
    end
    valid = 1'b0;
    vectors++;
    if (bus.drop_cnt_o !== 16'hFFFF || mdrop != 65535 || bus.count_o !== CW'(16)) begin
      miscompares++;
      $display("FAIL drop_sat: got drop=%h count=%0d exp ffff/16", bus.drop_cnt_o, bus.count_o);
    end
  endtask

  task automatic test_async_reset();
    do_clear(2'd1);
    for (int i = 0; i < 8; i++) begin
      set_rec(i + 1, 1'b0);
      cycle();
    end
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    vectors++;
    if (bus.count_o !== '0 || bus.rd_valid_o !== 1'b0 || bus.drop_cnt_o !== 16'd0 ||
        bus.triggered_o !== 1'b0 || bus.frozen_o !== 1'b0 || got_rec() !== '0) begin
      miscompares++;
      $display("FAIL async_reset: got count=%0d valid=%0b rec=%h exp all 0", bus.count_o, bus.rd_valid_o, got_rec());
    end
    valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    en = 1'b1; clr = 1'b0; valid = 1'b0; ready = 1'b0; trap = 1'b0; tag = 1'b0;
    mode = 2'd0; order = '0; pc = '0; insn = '0; wdata = '0; rd = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    test_reset();
    test_fifo();
    test_overwrite();
    test_trigger();
    test_trig_zero_and_clear();
    test_random();
    test_async_reset();
    test_drop_sat();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
